up_axi_bridge: RTL and testbench

Parametrised AXI4-Lite slave to processor-register (pcore) bridge, successor to the fixed 32-bit bridge. It converts one AXI4-Lite write and one AXI4-Lite read at a time into single-cycle `up_wreq`/`up_rreq` pulses on the pcore bus. The data width and ack timeout are configurable, and write strobes are forwarded. A missing pcore ack ends the transaction with a timeout pulse and an optional error response. It sits between the interconnect and every register-map pcore in the design.

---
 rtl/up_axi_bridge.sv | 182 ++++++++++++++++++
 tb/tb_up_axi_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_axi_bridge.sv
`default_nettype none
// ============================================================================
// up_axi_bridge -- AXI4-Lite slave to pcore register-bus bridge, one write and
// one read in flight at a time. Macro UP_AXI_BRIDGE_TIMEOUT_ERR_EN: SLVERR on timeout.
// Rev 1.0
// ============================================================================
module up_axi_bridge #(
  parameter int AXI_ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES    = 16,
  localparam int ADDR_LSB         = (DATA_WIDTH == 64) ? 3 : 2
) (
  input  logic                                  up_clk,
  input  logic                                  up_rstn,
  input  logic                                  up_axi_awvalid,
  output logic                                  up_axi_awready,
  input  logic [AXI_ADDRESS_WIDTH-1:0]          up_axi_awaddr,
  input  logic                                  up_axi_wvalid,
  output logic                                  up_axi_wready,
  input  logic [DATA_WIDTH-1:0]                 up_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]               up_axi_wstrb,
  output logic                                  up_axi_bvalid,
  input  logic                                  up_axi_bready,
  output logic [1:0]                            up_axi_bresp,
  input  logic                                  up_axi_arvalid,
  output logic                                  up_axi_arready,
  input  logic [AXI_ADDRESS_WIDTH-1:0]          up_axi_araddr,
  output logic                                  up_axi_rvalid,
  input  logic                                  up_axi_rready,
  output logic [1:0]                            up_axi_rresp,
  output logic [DATA_WIDTH-1:0]                 up_axi_rdata,
  output logic                                  up_wreq,
  output logic [AXI_ADDRESS_WIDTH-ADDR_LSB-1:0] up_waddr,
  output logic [DATA_WIDTH-1:0]                 up_wdata,
  output logic [DATA_WIDTH/8-1:0]               up_wstrb,
  input  logic                                  up_wack,
  output logic                                  up_rreq,
  output logic [AXI_ADDRESS_WIDTH-ADDR_LSB-1:0] up_raddr,
  input  logic [DATA_WIDTH-1:0]                 up_rdata,
  input  logic                                  up_rack,
  output logic                                  up_wtimeout,
  output logic                                  up_rtimeout
);
  localparam int UAW = AXI_ADDRESS_WIDTH - ADDR_LSB;
  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] C_DEAD = {(DATA_WIDTH/16){16'hdead}};
`ifdef UP_AXI_BRIDGE_TIMEOUT_ERR_EN
  localparam logic [1:0] C_TO_RESP = 2'b10;
`else
  localparam logic [1:0] C_TO_RESP = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_WAIT = 2'd2, W_RESP = 2'd3} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_WAIT = 2'd2, R_RESP = 2'd3} rstate_t;

  wstate_t                r_wstate, w_wnext;
  rstate_t                r_rstate, w_rnext;
  logic [7:0]             r_wcnt, r_rcnt;
  logic                   w_wto, w_rto;
  logic [UAW-1:0]         r_waddr, r_raddr;
  logic [DATA_WIDTH-1:0]  r_wdata, r_rdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic [1:0]             r_bresp, r_rresp;
  logic                   r_wtimeout, r_rtimeout;
  logic                   w_unused;

  // Byte-lane address bits have no meaning on the word-addressed pcore bus.
  assign w_unused = ^{up_axi_awaddr[ADDR_LSB-1:0], up_axi_araddr[ADDR_LSB-1:0]};

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end

  always_comb begin
    w_wnext = r_wstate;
    w_wto   = 1'b0;
    case (r_wstate)
      W_IDLE: if (up_axi_awvalid && up_axi_wvalid) w_wnext = W_REQ;
      W_REQ:  w_wnext = W_WAIT;
      W_WAIT: begin
        // An ack landing on the last counted cycle still wins over the timeout.
        if (up_wack) begin
          w_wnext = W_RESP;
        end else if (r_wcnt == C_TO_LAST) begin
          w_wnext = W_RESP;
          w_wto   = 1'b1;
        end
      end
      W_RESP: if (up_axi_bready) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    w_rnext = r_rstate;
    w_rto   = 1'b0;
    case (r_rstate)
      R_IDLE: if (up_axi_arvalid) w_rnext = R_REQ;
      R_REQ:  w_rnext = R_WAIT;
      R_WAIT: begin
        if (up_rack) begin
          w_rnext = R_RESP;
        end else if (r_rcnt == C_TO_LAST) begin
          w_rnext = R_RESP;
          w_rto   = 1'b1;
        end
      end
      R_RESP: if (up_axi_rready) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      r_wcnt     <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= 2'b00;
      r_wtimeout <= 1'b0;
    end else begin
      r_wtimeout <= w_wto;
      if (r_wstate == W_IDLE && w_wnext == W_REQ) begin
        r_waddr <= up_axi_awaddr[AXI_ADDRESS_WIDTH-1:ADDR_LSB];
        r_wdata <= up_axi_wdata;
        r_wstrb <= up_axi_wstrb;
      end
      if (r_wstate == W_REQ) r_wcnt <= '0;
      else if (r_wstate == W_WAIT) r_wcnt <= r_wcnt + 8'd1;
      if (r_wstate == W_WAIT && w_wnext == W_RESP) r_bresp <= w_wto ? C_TO_RESP : 2'b00;
      else if (r_wstate == W_RESP && up_axi_bready) r_bresp <= 2'b00;
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      r_rcnt     <= '0;
      r_raddr    <= '0;
      r_rdata    <= '0;
      r_rresp    <= 2'b00;
      r_rtimeout <= 1'b0;
    end else begin
      r_rtimeout <= w_rto;
      if (r_rstate == R_IDLE && w_rnext == R_REQ) r_raddr <= up_axi_araddr[AXI_ADDRESS_WIDTH-1:ADDR_LSB];
      if (r_rstate == R_REQ) r_rcnt <= '0;
      else if (r_rstate == R_WAIT) r_rcnt <= r_rcnt + 8'd1;
      if (r_rstate == R_WAIT && w_rnext == R_RESP) begin
        r_rdata <= up_rack ? up_rdata : C_DEAD;
        r_rresp <= w_rto ? C_TO_RESP : 2'b00;
      end else if (r_rstate == R_RESP && up_axi_rready) begin
        r_rdata <= '0;
        r_rresp <= 2'b00;
      end
    end
  end

  assign up_axi_awready = (r_wstate == W_REQ);
  assign up_axi_wready  = (r_wstate == W_REQ);
  assign up_wreq        = (r_wstate == W_REQ);
  assign up_axi_bvalid  = (r_wstate == W_RESP);
  assign up_axi_bresp   = r_bresp;
  assign up_waddr       = r_waddr;
  assign up_wdata       = r_wdata;
  assign up_wstrb       = r_wstrb;
  assign up_wtimeout    = r_wtimeout;

  assign up_axi_arready = (r_rstate == R_REQ);
  assign up_rreq        = (r_rstate == R_REQ);
  assign up_axi_rvalid  = (r_rstate == R_RESP);
  assign up_axi_rresp   = r_rresp;
  assign up_axi_rdata   = r_rdata;
  assign up_raddr       = r_raddr;
  assign up_rtimeout    = r_rtimeout;

endmodule
`default_nettype wire

// File: tb/tb_up_axi_bridge.sv
`default_nettype none
// tb_up_axi_bridge -- vector table plus hand sequences for up_axi_bridge,
// 32-bit and 64-bit instances sharing one clock and reset.
module tb_up_axi_bridge;
`ifdef UP_AXI_BRIDGE_TIMEOUT_ERR_EN
  localparam logic [1:0] C_TO_RESP = 2'b10;
`else
  localparam logic [1:0] C_TO_RESP = 2'b00;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [31:0] wdata, rdata, pc_rdata, uwdata;
  logic [3:0]  wstrb, uwstrb;
  logic [1:0]  bresp, rresp;
  logic        wreq, wack, rreq, rack, wto, rto;
  logic [13:0] uwaddr, uraddr;

  logic        a6_awvalid, a6_awready, a6_wvalid, a6_wready, a6_bvalid, a6_bready;
  logic        a6_arvalid, a6_arready, a6_rvalid, a6_rready;
  logic [15:0] a6_awaddr, a6_araddr;
  logic [63:0] a6_wdata, a6_rdata, a6_pc_rdata, a6_uwdata;
  logic [7:0]  a6_wstrb, a6_uwstrb;
  logic [1:0]  a6_bresp, a6_rresp;
  logic        a6_wreq, a6_wack, a6_rreq, a6_rack, a6_wto, a6_rto;
  logic [12:0] a6_uwaddr, a6_uraddr;

  up_axi_bridge u_dut32 (
    .up_clk(clk), .up_rstn(rstn),
    .up_axi_awvalid(awvalid), .up_axi_awready(awready), .up_axi_awaddr(awaddr),
    .up_axi_wvalid(wvalid), .up_axi_wready(wready), .up_axi_wdata(wdata), .up_axi_wstrb(wstrb),
    .up_axi_bvalid(bvalid), .up_axi_bready(bready), .up_axi_bresp(bresp),
    .up_axi_arvalid(arvalid), .up_axi_arready(arready), .up_axi_araddr(araddr),
    .up_axi_rvalid(rvalid), .up_axi_rready(rready), .up_axi_rresp(rresp), .up_axi_rdata(rdata),
    .up_wreq(wreq), .up_waddr(uwaddr), .up_wdata(uwdata), .up_wstrb(uwstrb), .up_wack(wack),
    .up_rreq(rreq), .up_raddr(uraddr), .up_rdata(pc_rdata), .up_rack(rack),
    .up_wtimeout(wto), .up_rtimeout(rto)
  );

  up_axi_bridge #(.DATA_WIDTH(64)) u_dut64 (
    .up_clk(clk), .up_rstn(rstn),
    .up_axi_awvalid(a6_awvalid), .up_axi_awready(a6_awready), .up_axi_awaddr(a6_awaddr),
    .up_axi_wvalid(a6_wvalid), .up_axi_wready(a6_wready), .up_axi_wdata(a6_wdata), .up_axi_wstrb(a6_wstrb),
    .up_axi_bvalid(a6_bvalid), .up_axi_bready(a6_bready), .up_axi_bresp(a6_bresp),
    .up_axi_arvalid(a6_arvalid), .up_axi_arready(a6_arready), .up_axi_araddr(a6_araddr),
    .up_axi_rvalid(a6_rvalid), .up_axi_rready(a6_rready), .up_axi_rresp(a6_rresp), .up_axi_rdata(a6_rdata),
    .up_wreq(a6_wreq), .up_waddr(a6_uwaddr), .up_wdata(a6_uwdata), .up_wstrb(a6_uwstrb), .up_wack(a6_wack),
    .up_rreq(a6_rreq), .up_raddr(a6_uraddr), .up_rdata(a6_pc_rdata), .up_rack(a6_rack),
    .up_wtimeout(a6_wto), .up_rtimeout(a6_rto)
  );

  logic [127:0] outs32, ctl64, dat64;
  assign outs32 = {19'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, wreq,
                   uwaddr, uwdata, uwstrb, rreq, uraddr, wto, rto};
  assign ctl64  = {81'd0, a6_awready, a6_wready, a6_bvalid, a6_bresp, a6_arready, a6_rvalid, a6_rresp,
                   a6_wreq, a6_uwaddr, a6_uwstrb, a6_rreq, a6_uraddr, a6_wto, a6_rto};
  assign dat64  = {a6_rdata, a6_uwdata};

  typedef struct {
    logic [1:0]  resp;
    int          lat;
    logic [63:0] data;
    int          to;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          is_rd;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          ack_dly;
    int          rdy_dly;
    logic [13:0] exp_uaddr;
    logic [1:0]  exp_resp;
    int          exp_lat;
    logic [31:0] exp_data;
    int          exp_to;
  } vec_t;
  vec_t vt[8];

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e, got;
    int c, to_cnt;
    e.resp = v.exp_resp; e.lat = v.exp_lat; e.data = 64'(v.exp_data); e.to = v.exp_to;
    sb.push_back(e);
    if (!v.is_rd) begin
      awvalid = 1'b1; wvalid = 1'b1; awaddr = v.addr; wdata = v.data; wstrb = v.strb;
    end else begin
      arvalid = 1'b1; araddr = v.addr;
    end
    tick;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    if (!v.is_rd) begin
      chk("wreq/awready/wready", 128'({wreq, awready, wready}), 128'(3'b111));
      chk("up_waddr", 128'(uwaddr), 128'(v.exp_uaddr));
      chk("up_wdata", 128'(uwdata), 128'(v.exp_data));
      chk("up_wstrb", 128'(uwstrb), 128'(v.strb));
    end else begin
      chk("rreq/arready", 128'({rreq, arready}), 128'(2'b11));
      chk("up_raddr", 128'(uraddr), 128'(v.exp_uaddr));
    end
    to_cnt = 0;
    for (c = 0; c < 200; c++) begin
      if (v.is_rd ? rto : wto) to_cnt++;
      if (v.is_rd ? rvalid : bvalid) break;
      if (c == 1) chk("req one cycle", 128'(v.is_rd ? rreq : wreq), 128'(0));
      wack = !v.is_rd && (c == v.ack_dly);
      rack = v.is_rd && (c == v.ack_dly);
      pc_rdata = (c == v.ack_dly) ? v.data : 32'h5A5A_5A5A;
      tick;
    end
    wack = 1'b0; rack = 1'b0; pc_rdata = 32'h0;
    got = sb.pop_front();
    chk("latency", 128'(c), 128'(got.lat));
    chk("timeout pulses", 128'(to_cnt), 128'(got.to));
    chk("resp", 128'(v.is_rd ? rresp : bresp), 128'(got.resp));
    if (v.is_rd) chk("rdata", 128'(rdata), 128'(got.data));
    for (int k = 0; k < v.rdy_dly; k++) begin
      tick;
      chk("valid hold", 128'(v.is_rd ? rvalid : bvalid), 128'(1));
      if (v.is_rd) chk("rdata hold", 128'(rdata), 128'(got.data));
    end
    bready = !v.is_rd; rready = v.is_rd;
    tick;
    bready = 1'b0; rready = 1'b0;
    chk("valid drop", 128'(v.is_rd ? rvalid : bvalid), 128'(0));
    if (v.is_rd) chk("rdata cleared", 128'(rdata), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e, got;
    int bcyc, rcyc, bcnt, rcnt, c, cnt;
    logic [31:0] rd_cap;

    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0; wack = 0; rack = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; pc_rdata = 0;
    a6_awvalid = 0; a6_wvalid = 0; a6_arvalid = 0; a6_bready = 0; a6_rready = 0;
    a6_wack = 0; a6_rack = 0; a6_awaddr = 0; a6_araddr = 0; a6_wdata = 0; a6_wstrb = 0; a6_pc_rdata = 0;

    //         rd    addr        data          strb  ack rdy  uaddr      resp       lat data          to
    vt[0] = '{1'b0, 16'h0010, 32'hA5A5_1234, 4'hC, 2,  0, 14'h0004, 2'b00,     3,  32'hA5A5_1234, 0};
    vt[1] = '{1'b1, 16'h0020, 32'hCAFE_F00D, 4'h0, 2,  5, 14'h0008, 2'b00,     3,  32'hCAFE_F00D, 0};
    vt[2] = '{1'b1, 16'h0030, 32'h1111_2222, 4'h0, -1, 0, 14'h000C, C_TO_RESP, 17, 32'hDEAD_DEAD, 1};
    vt[3] = '{1'b0, 16'h0044, 32'h1234_5678, 4'hF, 1,  0, 14'h0011, 2'b00,     2,  32'h1234_5678, 0};
    vt[4] = '{1'b0, 16'h0100, 32'h0BAD_F00D, 4'h3, -1, 2, 14'h0040, C_TO_RESP, 17, 32'h0BAD_F00D, 1};
    vt[5] = '{1'b1, 16'hFFFC, 32'h0BAD_BEEF, 4'h0, 16, 0, 14'h3FFF, 2'b00,     17, 32'h0BAD_BEEF, 0};
    vt[6] = '{1'b0, 16'h8000, 32'hFFFF_0000, 4'h1, 16, 1, 14'h2000, 2'b00,     17, 32'hFFFF_0000, 0};
    vt[7] = '{1'b0, 16'h0013, 32'h0000_00C3, 4'h8, 3,  0, 14'h0004, 2'b00,     4,  32'h0000_00C3, 0};

    #1 rstn = 1'b0;
    tick; tick;
    chk("reset outputs 32", outs32, 128'(0));
    chk("reset ctl 64", ctl64, 128'(0));
    chk("reset data 64", dat64, 128'(0));
    rstn = 1'b1;
    tick;

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Acks while idle must not start or complete anything.
    wack = 1'b1; rack = 1'b1; pc_rdata = 32'hFFFF_FFFF;
    tick; tick;
    wack = 1'b0; rack = 1'b0; pc_rdata = 32'h0;
    tick;
    chk("idle ack ignored", 128'({bvalid, rvalid, wto, rto, rdata}), 128'(0));

    // Simultaneous write and read; a read ack during R_REQ must be ignored.
    e = '{2'b00, 2, 64'h0, 0}; sb.push_back(e);
    e = '{2'b00, 4, 64'h600D_CAFE, 0}; sb.push_back(e);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 16'h0050; wdata = 32'h0000_0077; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 16'h0060;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("both req", 128'({wreq, rreq}), 128'(2'b11));
    chk("both addr", 128'({uwaddr, uraddr}), 128'({14'h0014, 14'h0018}));
    bready = 1'b1; rready = 1'b1;
    bcyc = -1; rcyc = -1; bcnt = 0; rcnt = 0; rd_cap = 32'h0;
    for (int k = 0; k < 12; k++) begin
      if (bvalid) begin bcnt++; if (bcyc < 0) bcyc = k; end
      if (rvalid) begin rcnt++; if (rcyc < 0) begin rcyc = k; rd_cap = rdata; end end
      wack = (k == 1);
      rack = (k == 0) || (k == 3);
      pc_rdata = (k == 3) ? 32'h600D_CAFE : 32'h1234_5678;
      tick;
    end
    bready = 1'b0; rready = 1'b0; wack = 1'b0; rack = 1'b0; pc_rdata = 32'h0;
    got = sb.pop_front();
    chk("simul write latency", 128'(bcyc), 128'(got.lat));
    chk("simul bvalid cycles", 128'(bcnt), 128'(1));
    got = sb.pop_front();
    chk("simul read latency", 128'(rcyc), 128'(got.lat));
    chk("simul rvalid cycles", 128'(rcnt), 128'(1));
    chk("simul rdata", 128'(rd_cap), 128'(got.data));

    // Reset while waiting for a write ack.
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 16'h0070; wdata = 32'hDDDD_EEEE; wstrb = 4'hF;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    tick; tick;
    #2 rstn = 1'b0;
    #1 chk("async reset outputs", outs32, 128'(0));
    tick; tick;
    rstn = 1'b1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (bvalid) cnt++;
      tick;
    end
    chk("no bvalid after reset", 128'(cnt), 128'(0));
    run_vec(vt[0]);

    // 64-bit instance: write then read timeout.
    a6_awvalid = 1'b1; a6_wvalid = 1'b1; a6_awaddr = 16'h0018;
    a6_wdata = 64'h0123_4567_89AB_CDEF; a6_wstrb = 8'hF0;
    tick;
    a6_awvalid = 1'b0; a6_wvalid = 1'b0;
    chk("w64 wreq", 128'(a6_wreq), 128'(1));
    chk("w64 up_waddr", 128'(a6_uwaddr), 128'(13'h0003));
    chk("w64 up_wstrb", 128'(a6_uwstrb), 128'(8'hF0));
    chk("w64 up_wdata", 128'(a6_uwdata), 128'(64'h0123_4567_89AB_CDEF));
    tick;
    a6_wack = 1'b1;
    tick;
    a6_wack = 1'b0;
    chk("w64 bvalid/bresp", 128'({a6_bvalid, a6_bresp}), 128'(3'b100));
    a6_bready = 1'b1;
    tick;
    a6_bready = 1'b0;
    chk("w64 bvalid drop", 128'(a6_bvalid), 128'(0));

    e = '{C_TO_RESP, 17, 64'hDEAD_DEAD_DEAD_DEAD, 1}; sb.push_back(e);
    a6_arvalid = 1'b1; a6_araddr = 16'h0040;
    tick;
    a6_arvalid = 1'b0;
    chk("r64 rreq/raddr", 128'({a6_rreq, a6_uraddr}), 128'({1'b1, 13'h0008}));
    cnt = 0;
    for (c = 0; c < 100; c++) begin
      if (a6_rto) cnt++;
      if (a6_rvalid) break;
      tick;
    end
    got = sb.pop_front();
    chk("r64 latency", 128'(c), 128'(got.lat));
    chk("r64 timeout pulses", 128'(cnt), 128'(got.to));
    chk("r64 rdata", 128'(a6_rdata), 128'(got.data));
    chk("r64 rresp", 128'(a6_rresp), 128'(got.resp));
    a6_rready = 1'b1;
    tick;
    a6_rready = 1'b0;
    chk("r64 rdata cleared", 128'({a6_rvalid, a6_rdata}), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
